// File: rtl/example_input_cond_if.sv
// Raw board inputs and conditioned levels for example_input_cond.
// master drives the raw inputs; slave is the conditioning stage.
interface example_input_cond_if;
  logic       a_raw;
  logic       b_raw;
  logic       c_raw;
  logic [3:0] d_raw;
  logic       A;
  logic       B;
  logic       C;
  logic [3:0] D;
  logic       d_valid;
  logic       d_upd;

  modport master (
    output a_raw, b_raw, c_raw, d_raw,
    input  A, B, C, D, d_valid, d_upd
  );

  modport slave (
    input  a_raw, b_raw, c_raw, d_raw,
    output A, B, C, D, d_valid, d_upd
  );
endinterface

// File: rtl/example_input_cond.sv
// Input conditioning: 2-flop sync, A/B/C debounce, D stability qualifier.
// Define EXAMPLE_INCOND_BYPASS_EN to replace filtering with a plain registered pass-through.
module example_input_cond #(
  parameter int DB_CYCLES          = 16,
  parameter int CODE_STABLE_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rstN,
  example_input_cond_if.slave  io
);

  // Bit order: {d[3:0], c, b, a}
  logic [6:0] raw;
  logic [6:0] sync1;
  logic [6:0] sync2;
  logic [2:0] abc;
  logic [3:0] d_q;
  logic       d_valid_q;
  logic       d_upd_q;

  assign raw        = {io.d_raw, io.c_raw, io.b_raw, io.a_raw};
  assign io.A       = abc[0];
  assign io.B       = abc[1];
  assign io.C       = abc[2];
  assign io.D       = d_q;
  assign io.d_valid = d_valid_q;
  assign io.d_upd   = d_upd_q;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

`ifdef EXAMPLE_INCOND_BYPASS_EN

  always_ff @(posedge clk) begin
    if (!rstN) begin
      abc       <= '0;
      d_q       <= '0;
      d_valid_q <= 1'b0;
      d_upd_q   <= 1'b0;
    end else begin
      abc       <= sync2[2:0];
      d_q       <= sync2[6:3];
      d_valid_q <= 1'b1;
      d_upd_q   <= (sync2[6:3] != d_q);
    end
  end

`else

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam int QW = $clog2(CODE_STABLE_CYCLES + 1);

  logic [CW-1:0] cnt [3];
  logic [3:0]    cand;
  logic [QW-1:0] qcnt;
  logic [3:0]    sd;

  assign sd = sync2[6:3];

  always_ff @(posedge clk) begin
    if (!rstN) begin
      abc <= '0;
      for (int unsigned i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2[i] == abc[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DB_CYCLES - 1)) begin
          abc[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // qcnt parks at its terminal value; the load test keeps re-qualifying the same code silent
  always_ff @(posedge clk) begin
    if (!rstN) begin
      cand      <= '0;
      qcnt      <= '0;
      d_q       <= '0;
      d_valid_q <= 1'b0;
      d_upd_q   <= 1'b0;
    end else begin
      d_upd_q <= 1'b0;
      if (sd != cand) begin
        cand <= sd;
        qcnt <= '0;
      end else if (qcnt == QW'(CODE_STABLE_CYCLES - 1)) begin
        if (!d_valid_q || cand != d_q) begin
          d_q       <= cand;
          d_valid_q <= 1'b1;
          d_upd_q   <= 1'b1;
        end
      end else begin
        qcnt <= qcnt + 1'b1;
      end
    end
  end

`endif

endmodule

// File: tb/tb_example_input_cond.sv
// Scoreboard bench for example_input_cond: expected output transitions are queued
// with their edge numbers when inputs are driven and matched when outputs change.
module tb_example_input_cond;

  localparam int DB = 4;
  localparam int CS = 3;
`ifdef EXAMPLE_INCOND_BYPASS_EN
  localparam int DBL = 2;
  localparam int CSL = 2;
`else
  localparam int DBL = DB + 1;
  localparam int CSL = CS + 2;
`endif

  localparam int S_A = 0, S_B = 1, S_C = 2, S_D = 3, S_V = 4, S_U = 5;

  typedef struct {
    int sig;
    int at;
    int val;
  } ev_t;

  logic  clk = 1'b0;
  logic  rstN;
  int    edge_n = 0;
  int    n_cmp = 0;
  int    n_err = 0;
  bit    mon_en = 1'b0;
  int    prev [6];
  ev_t   sb [$];
  string names [6] = '{"A", "B", "C", "D", "d_valid", "d_upd"};

  example_input_cond_if io();

  example_input_cond #(
    .DB_CYCLES          (DB),
    .CODE_STABLE_CYCLES (CS)
  ) dut (
    .clk  (clk),
    .rstN (rstN),
    .io   (io)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int get_sig(input int s);
    case (s)
      S_A:     return int'(io.A);
      S_B:     return int'(io.B);
      S_C:     return int'(io.C);
      S_D:     return int'(io.D);
      S_V:     return int'(io.d_valid);
      default: return int'(io.d_upd);
    endcase
  endfunction

  task automatic snap();
    for (int s = 0; s < 6; s++) prev[s] = get_sig(s);
  endtask

  task automatic push(input int sig, input int at, input int val);
    ev_t e;
    e.sig = sig;
    e.at  = at;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    for (int s = 0; s < 6; s++) check({tag, "_", names[s]}, get_sig(s), 0);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int s = 0; s < 6; s++) begin
        int cur;
        int idx;
        cur = get_sig(s);
        if (cur != prev[s]) begin
          idx = -1;
          for (int i = 0; i < sb.size(); i++) begin
            if (idx < 0 && sb[i].sig == s) idx = i;
          end
          if (idx < 0) begin
            check({"unexpected_", names[s]}, cur, prev[s]);
          end else begin
            check({names[s], "_edge"}, edge_n, sb[idx].at);
            check({names[s], "_val"}, cur, sb[idx].val);
            sb.delete(idx);
          end
          prev[s] = cur;
        end
      end
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].at < edge_n) begin
          check({"late_", names[sb[i].sig]}, edge_n, sb[i].at);
          sb.delete(i);
        end
      end
    end
  end

  initial begin
    int first;
    rstN     = 1'b0;
    io.a_raw = 1'b1;
    io.b_raw = 1'b1;
    io.c_raw = 1'b1;
    io.d_raw = 4'hF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_all_zero("reset");
    end

    io.a_raw = 1'b0;
    io.b_raw = 1'b0;
    io.c_raw = 1'b0;
    io.d_raw = 4'h0;
    rstN     = 1'b1;
    snap();
    mon_en   = 1'b1;
`ifdef EXAMPLE_INCOND_BYPASS_EN
    push(S_V, edge_n + 1, 1);
    wait_n(8);

    // one-cycle glitch passes straight through
    first    = edge_n + 1;
    io.c_raw = 1'b1;
    push(S_C, first + DBL, 1);
    push(S_C, first + DBL + 1, 0);
    wait_n(1);
    io.c_raw = 1'b0;
    wait_n(8);

    first    = edge_n + 1;
    io.d_raw = 4'h8;
    push(S_D, first + CSL, 8);
    push(S_U, first + CSL, 1);
    push(S_U, first + CSL + 1, 0);
    wait_n(8);

    first    = edge_n + 1;
    io.a_raw = 1'b1;
    push(S_A, first + DBL, 1);
    wait_n(8);
    check("bypass_D_hold", int'(io.D), 8);
`else
    // all-zero code qualifies on its own after release
    push(S_V, edge_n + CS, 1);
    push(S_U, edge_n + CS, 1);
    push(S_U, edge_n + CS + 1, 0);
    wait_n(10);

    first    = edge_n + 1;
    io.a_raw = 1'b1;
    push(S_A, first + DBL, 1);
    wait_n(12);
    check("B_idle", int'(io.B), 0);
    check("C_idle", int'(io.C), 0);

    // pulse shorter than DB is filtered
    io.b_raw = 1'b1;
    wait_n(DB - 1);
    io.b_raw = 1'b0;
    wait_n(20);
    check("B_filtered", int'(io.B), 0);
    first    = edge_n + 1;
    io.b_raw = 1'b1;
    push(S_B, first + DBL, 1);
    wait_n(12);

    first    = edge_n + 1;
    io.d_raw = 4'h4;
    push(S_D, first + CSL, 4);
    push(S_U, first + CSL, 1);
    push(S_U, first + CSL + 1, 0);
    wait_n(10);
    // code held CS-1 cycles then reverted: no update
    io.d_raw = 4'h6;
    wait_n(CS - 1);
    io.d_raw = 4'h4;
    wait_n(12);
    check("D_hold", int'(io.D), 4);

    // pulse of exactly DB cycles passes
    first    = edge_n + 1;
    io.c_raw = 1'b1;
    push(S_C, first + DBL, 1);
    push(S_C, first + DB + DBL, 0);
    wait_n(DB);
    io.c_raw = 1'b0;
    wait_n(14);

    first    = edge_n + 1;
    io.a_raw = 1'b0;
    io.b_raw = 1'b0;
    io.c_raw = 1'b1;
    io.d_raw = 4'h9;
    push(S_A, first + DBL, 0);
    push(S_B, first + DBL, 0);
    push(S_C, first + DBL, 1);
    push(S_D, first + CSL, 9);
    push(S_U, first + CSL, 1);
    push(S_U, first + CSL + 1, 0);
    wait_n(14);
    check("sb_drained_pre_reset", sb.size(), 0);

    // reset mid-count discards debounce progress
    io.a_raw = 1'b1;
    wait_n(3);
    mon_en = 1'b0;
    rstN   = 1'b0;
    wait_n(1);
    check_all_zero("midrst");
    rstN  = 1'b1;
    snap();
    mon_en = 1'b1;
    first  = edge_n + 1;
    push(S_A, first + DBL, 1);
    push(S_C, first + DBL, 1);
    push(S_D, first + CSL, 9);
    push(S_V, first + CSL, 1);
    push(S_U, first + CSL, 1);
    push(S_U, first + CSL + 1, 0);
    wait_n(14);
    check("A_after_rst", int'(io.A), 1);
`endif
    check("sb_drained", sb.size(), 0);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/example_input_cond.md
Name: example_input_cond

Overview:
- Input conditioning stage that feeds the example FSM (A, B, C, D[3:0] -> Q[2:0]).
- Takes raw asynchronous board inputs (buttons, 4-bit DIP code).
- Synchronises each input.
- Debounces the single-bit inputs A, B, C.
- Qualifies the 4-bit code D as stable before the FSM sees it, so the FSM's A, A&B and D==const decisions act on clean, glitch-free levels.

Parameters:
- DB_CYCLES, default 16: consecutive synced-mismatch cycles required before A/B/C output toggles; legal range 1 or more.
- CODE_STABLE_CYCLES, default 8: consecutive cycles the synced code must hold before D is updated; legal range 1 or more.

Ports:
- clk  in  1  system clock, rising edge
- rstN  in  1  synchronous, active-low reset
- a_raw  in  1  raw asynchronous input A
- b_raw  in  1  raw asynchronous input B
- c_raw  in  1  raw asynchronous input C
- d_raw  in  4  raw asynchronous code D
- A  out  1  debounced A level
- B  out  1  debounced B level
- C  out  1  debounced C level
- D  out  4  last qualified code
- d_valid  out  1  high once any code has been qualified since reset
- d_upd  out  1  one-cycle pulse when D loads a new value

Behaviour:
- Clocking and reset:
  - One clock domain: clk.
  - rstN is synchronous, active-low, sampled on the rising edge of clk.
  - While rstN is low at an edge, all of the following reset to 0: synchroniser flops, counters, the candidate code, A, B, C, D, d_valid, d_upd.
  - Reset mid-count discards all progress; counting restarts from zero after release.
- Synchroniser:
  - Two flops per bit (a, b, c, d[3:0]), reset 0.
  - sync2 reflects raw two edges after capture.
- Debounce, per channel A/B/C, independent:
  - Counter cnt, width $clog2(DB_CYCLES+1).
  - If sync2 == out: cnt <= 0.
  - Else if cnt == DB_CYCLES-1: out <= sync2, cnt <= 0.
  - Else cnt <= cnt+1.
- Debounce latency:
  - A raw change first sampled at edge 1 appears on the output after edge DB_CYCLES+2.
  - A pulse whose synced width is shorter than DB_CYCLES never reaches the output.
  - Any return to equality clears cnt; there is no hysteresis beyond this.
- Code qualifier, state: cand[3:0], qcnt.
  - If sync2_d != cand: cand <= sync2_d, qcnt <= 0.
  - Else if qcnt == CODE_STABLE_CYCLES-1:
    - qcnt saturates; no further loads while the code is unchanged.
    - On the qualifying edge, if (!d_valid || cand != D): D <= cand, d_valid <= 1, d_upd <= 1 for exactly one cycle.
    - Otherwise D is unchanged and there is no pulse.
  - Else qcnt <= qcnt+1.
  - d_upd defaults to 0 every cycle.
- Code qualifier timing:
  - cand resets to 0, so a raw code of 0000 held from reset qualifies after CODE_STABLE_CYCLES cycles of sync2 = 0000. At that point d_valid rises and d_upd pulses with D=0000.
  - A raw code change sampled at edge 1 loads D after edge CODE_STABLE_CYCLES+3: one extra edge for the cand load.
  - Any mismatch restarts qualification; D holds its previous value meanwhile.
- d_valid never falls except on reset.
- Channels and the code path are fully independent; simultaneous changes on all inputs are each processed with their own latency.
- All outputs are registered; there is no combinational path from any raw input to any output.

Optional Feature:
- Macro: EXAMPLE_INCOND_BYPASS_EN.
- When defined:
  - Debounce and qualification logic are compiled out.
  - A/B/C = the respective sync2, registered once more.
  - D <= sync2_d every cycle; d_valid = 1 from the first edge after reset release.
  - d_upd pulses on any cycle D changes value.
  - Intended for fast simulation of the downstream FSM.
- When undefined: behaviour exactly as above.

Test Plan (DB_CYCLES=4, CODE_STABLE_CYCLES=3):
1. Hold rstN=0 for 3 edges with all raw inputs =1 -> A=B=C=0, D=0000, d_valid=0, d_upd=0 throughout reset.
2. After reset, a_raw 0->1 held -> A=0 through edge 5, A=1 after edge 6; B and C stay 0.
3. b_raw high for 3 cycles then low -> B stays 0 for 20 cycles. b_raw held high -> B=1 after edge 6.
4. d_raw=0100 held -> D=0100, d_valid=1 and single-cycle d_upd after edge 6. Then d_raw=0110 for 2 cycles and back to 0100 -> D stays 0100, no d_upd.
5. a_raw high held; rstN pulsed low for 1 edge at edge 4 -> A=0, and A=1 only after the 6th edge following release.
6. Build with EXAMPLE_INCOND_BYPASS_EN; c_raw 1-cycle glitch -> C shows the 1-cycle pulse 3 edges later. d_raw 1000 -> D=1000 with d_upd 3 edges later.
